// File: rtl/rf_pkg.sv
// Shared widths and types for the integer register file.
package rf_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ABI_A0     = 10;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: issue handshake, writeback clear, per-port busy and hazard.
module rf_scoreboard #(
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_RD-1:0]            rd_en,
    input  logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr,
    input  logic                         we,
    input  logic [ADDR_W-1:0]            wa,
    input  logic                         issue_valid,
    input  logic [ADDR_W-1:0]            issue_rd,
    output logic                         issue_ready,
    output logic [NUM_RD-1:0]            rd_busy,
    output logic                         hazard
);
    localparam int DEPTH     = 2 ** ADDR_W;
    localparam bit ZERO_EN   = (ZERO_REG != 0);
    localparam bit BYPASS_EN = (BYPASS != 0);

    logic [DEPTH-1:0] r_busy;
    logic             w_issue_zero;
    logic             w_accept;

    assign w_issue_zero = (issue_rd == '0);
    assign issue_ready  = ~r_busy[issue_rd] | (ZERO_EN & w_issue_zero);
    assign w_accept     = issue_valid & issue_ready;

    // Set is scheduled after clear so a new producer wins over the retiring one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            if (we && (wa != '0))
                r_busy[wa] <= 1'b0;
            if (w_accept && !w_issue_zero)
                r_busy[issue_rd] <= 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd_busy
        assign rd_busy[g] = r_busy[rd_addr[g]]
                          & ~(BYPASS_EN & we & (wa == rd_addr[g]))
                          & ~(ZERO_EN & (rd_addr[g] == '0));
    end

    assign hazard = |(rd_en & rd_busy);
endmodule

// File: rtl/reg_file.sv
// RISC-V integer register file: NUM_RD combinational read ports, one write port, busy scoreboard.
module reg_file
    import rf_pkg::*;
#(
    parameter int DATA_W   = XLEN,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    parameter int A0_IDX   = ABI_A0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_RD-1:0]             rd_en,
    input  logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0][DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]             rd_busy,
    output logic                          hazard,
    input  logic                          WE3,
    input  logic [ADDR_W-1:0]             AD3,
    input  logic [DATA_W-1:0]             WD3,
    input  logic                          issue_valid,
    input  logic [ADDR_W-1:0]             issue_rd,
    output logic                          issue_ready,
    output logic [DATA_W-1:0]             a0
);
    localparam int              DEPTH     = 2 ** ADDR_W;
    localparam bit              ZERO_EN   = (ZERO_REG != 0);
    localparam bit              BYPASS_EN = (BYPASS != 0);
    localparam logic [ADDR_W-1:0] A0_ADDR = ADDR_W'(A0_IDX);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_wr_en;

    assign w_wr_en = WE3 & ~(ZERO_EN & (AD3 == '0));

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_mem <= '{default: '0};
        else if (w_wr_en)
            r_mem[AD3] <= WD3;
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        always_comb begin
            rd_data[g] = r_mem[rd_addr[g]];
            if (ZERO_EN && (rd_addr[g] == '0))
                rd_data[g] = '0;
            else if (BYPASS_EN && WE3 && (AD3 == rd_addr[g]))
                rd_data[g] = WD3;
        end
    end

    // a0 is a display tap of the stored value, deliberately not bypassed.
    assign a0 = r_mem[A0_ADDR];

    rf_scoreboard #(
        .ADDR_W  (ADDR_W),
        .NUM_RD  (NUM_RD),
        .BYPASS  (BYPASS),
        .ZERO_REG(ZERO_REG)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .we         (WE3),
        .wa         (AD3),
        .issue_valid(issue_valid),
        .issue_rd   (issue_rd),
        .issue_ready(issue_ready),
        .rd_busy    (rd_busy),
        .hazard     (hazard)
    );
endmodule

// File: tb/tb_reg_file.sv
// Directed and randomized bench for reg_file against an array-based reference model.
module tb_reg_file;
    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      rd_en;
    logic [1:0][4:0] rd_addr;
    logic [1:0][31:0] rd_data;
    logic [1:0]      rd_busy;
    logic            hazard;
    logic            WE3;
    logic [4:0]      AD3;
    logic [31:0]     WD3;
    logic            issue_valid;
    logic [4:0]      issue_rd;
    logic            issue_ready;
    logic [31:0]     a0;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [31:0] m_mem [32];
    bit          m_busy [32];

    reg_file dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .hazard     (hazard),
        .WE3        (WE3),
        .AD3        (AD3),
        .WD3        (WD3),
        .issue_valid(issue_valid),
        .issue_rd   (issue_rd),
        .issue_ready(issue_ready),
        .a0         (a0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_data(input logic [4:0] a);
        if (a == 5'd0)            return 32'd0;
        if (WE3 && AD3 == a)      return WD3;
        return m_mem[a];
    endfunction

    function automatic bit exp_busy(input logic [4:0] a);
        return (a != 5'd0) && m_busy[a] && !(WE3 && AD3 == a);
    endfunction

    // Reference model: architectural state updated once per clock edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                m_mem[i]  <= 32'd0;
                m_busy[i] <= 1'b0;
            end
        end else begin
            if (WE3 && AD3 != 5'd0) begin
                m_mem[AD3]  <= WD3;
                m_busy[AD3] <= 1'b0;
            end
            if (issue_valid && issue_rd != 5'd0 && !m_busy[issue_rd])
                m_busy[issue_rd] <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit hz;
            hz = 1'b0;
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("rd_data[%0d]", p), rd_data[p], exp_data(rd_addr[p]));
                chk($sformatf("rd_busy[%0d]", p), {31'd0, rd_busy[p]}, {31'd0, exp_busy(rd_addr[p])});
                hz = hz | (rd_en[p] & exp_busy(rd_addr[p]));
            end
            chk("hazard", {31'd0, hazard}, {31'd0, hz});
            chk("issue_ready", {31'd0, issue_ready},
                {31'd0, (issue_rd == 5'd0) || !m_busy[issue_rd]});
            chk("a0", a0, m_mem[10]);
        end
    end

    task automatic idle();
        WE3 = 1'b0; AD3 = '0; WD3 = '0;
        issue_valid = 1'b0; issue_rd = '0;
        rd_en = '0; rd_addr = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        step();
        step();
        chk_en = 1'b1;
        rst_n  = 1'b1;

        // 1: reset clears data and pending busy
        WE3 = 1; AD3 = 5; WD3 = 32'hDEAD; rd_addr[0] = 5;
        @(negedge clk); chk("t1 bypass x5", rd_data[0], 32'hDEAD);
        step();
        idle(); rd_addr[0] = 5; issue_valid = 1; issue_rd = 5;
        @(negedge clk); chk("t1 stored x5", rd_data[0], 32'hDEAD);
        step();
        idle(); rst_n = 0;
        step();
        rst_n = 1; rd_addr[0] = 5; rd_addr[1] = 5; rd_en = 2'b11; issue_rd = 5;
        @(negedge clk);
        chk("t1 x5 after reset", rd_data[0], 32'd0);
        chk("t1 a0", a0, 32'd0);
        chk("t1 rd_busy", {30'd0, rd_busy}, 32'd0);
        chk("t1 issue_ready", {31'd0, issue_ready}, 32'd1);

        // 2: x0 ignores writes and issues
        idle(); WE3 = 1; AD3 = 0; WD3 = 32'hFFFF_FFFF; issue_valid = 1; issue_rd = 0;
        @(negedge clk); chk("t2 x0 same cycle", rd_data[0], 32'd0);
        step();
        idle(); rd_en = 2'b01; issue_rd = 0;
        @(negedge clk);
        chk("t2 x0 read", rd_data[0], 32'd0);
        chk("t2 x0 busy", {31'd0, rd_busy[0]}, 32'd0);
        chk("t2 x0 ready", {31'd0, issue_ready}, 32'd1);
        step();

        // 3: write-to-read bypass
        idle(); WE3 = 1; AD3 = 7; WD3 = 32'd1;
        step();
        idle(); WE3 = 1; AD3 = 7; WD3 = 32'h1234; rd_addr[0] = 7;
        @(negedge clk);
        chk("t3 bypass data", rd_data[0], 32'h1234);
        chk("t3 bypass busy", {31'd0, rd_busy[0]}, 32'd0);
        step();
        idle(); rd_addr[0] = 7;
        @(negedge clk); chk("t3 stored", rd_data[0], 32'h1234);
        step();

        // 4: RAW hazard and its release by writeback
        idle(); issue_valid = 1; issue_rd = 3;
        step();
        idle(); rd_en = 2'b10; rd_addr[1] = 3;
        @(negedge clk);
        chk("t4 rd_busy", {31'd0, rd_busy[1]}, 32'd1);
        chk("t4 hazard", {31'd0, hazard}, 32'd1);
        step();
        WE3 = 1; AD3 = 3; WD3 = 32'h55;
        @(negedge clk);
        chk("t4 hazard on wb", {31'd0, hazard}, 32'd0);
        chk("t4 wb data", rd_data[1], 32'h55);
        step();

        // 5: WAW stall and set-over-clear priority
        idle(); issue_valid = 1; issue_rd = 4;
        @(negedge clk); chk("t5 first ready", {31'd0, issue_ready}, 32'd1);
        step();
        @(negedge clk); chk("t5 second ready", {31'd0, issue_ready}, 32'd0);
        step();
        @(negedge clk); chk("t5 held ready", {31'd0, issue_ready}, 32'd0);
        WE3 = 1; AD3 = 4; WD3 = 32'h9; issue_valid = 0;
        step();
        WE3 = 1; AD3 = 4; WD3 = 32'hA; issue_valid = 1;
        @(negedge clk); chk("t5 ready after clear", {31'd0, issue_ready}, 32'd1);
        step();
        idle(); rd_en = 2'b01; rd_addr[0] = 4; issue_rd = 4;
        @(negedge clk);
        chk("t5 set wins busy", {31'd0, rd_busy[0]}, 32'd1);
        chk("t5 set wins ready", {31'd0, issue_ready}, 32'd0);
        step();

        // 6: a0 shows stored value only
        idle(); WE3 = 1; AD3 = 10; WD3 = 32'hCAFE_0000;
        @(negedge clk); chk("t6 a0 before edge", a0, 32'd0);
        step();
        idle();
        @(negedge clk); chk("t6 a0 after edge", a0, 32'hCAFE_0000);
        step();

        for (int n = 0; n < 3000; n++) begin
            rst_n       = ($urandom_range(0, 299) != 0);
            WE3         = 1'($urandom_range(0, 1));
            AD3         = 5'($urandom_range(0, 11));
            WD3         = $urandom();
            issue_valid = 1'($urandom_range(0, 1));
            issue_rd    = 5'($urandom_range(0, 11));
            rd_en       = 2'($urandom_range(0, 3));
            for (int p = 0; p < 2; p++)
                rd_addr[p] = ($urandom_range(0, 2) == 0) ? AD3 : 5'($urandom_range(0, 11));
            step();
        end

        idle(); rst_n = 1;
        step();
        step();
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
